rv32_exec_ctrl: RTL and testbench
=================================

Name: rv32_exec_ctrl

Overview:
- Execute/control stage of the single-cycle RV32I core.
- Combines three functions:
  - Control-signal generation from the decoded fields op, func3 and func7.
  - The 32-bit ALU with its operand muxes.
  - Branch-condition evaluation and next-PC computation.
- Sits between the IDU/GPR read stage and the data memory/GPR writeback. All outputs are registered, so results appear one cycle after inputs.

Parameters:
- XLEN, 32, datapath width. Only 32 is supported.
- RESET_PC, 32'h80000000, NextPC output value while in reset.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- in_valid  in  1  input fields are valid this cycle.
- op  in  7  opcode, inst[6:0].
- func3  in  3  inst[14:12].
- func7  in  7  inst[31:25].
- pc  in  32  PC of the instruction.
- rs1_data  in  32  GPR rs1 read data.
- rs2_data  in  32  GPR rs2 read data.
- imm  in  32  immediate, already sign-extended by the IDU according to ExtOP.
- ExtOP  out  3  immediate format: I=000, U=001, S=010, B=011, J=100. Combinational, because the IDU needs it in the same cycle.
- out_valid  out  1  registered in_valid.
- RegWr  out  1  write rd.
- MemToReg  out  1  writeback source is memory.
- MemRd  out  1  load.
- MemWr  out  1  store.
- MemOp  out  3  equals func3 for load/store, 000 otherwise.
- ALUout  out  32  ALU result; also the memory address.
- NextPC  out  32  next PC.
- illegal  out  1  unsupported opcode.

Behaviour:
- Reset:
  - rst low asynchronously clears every registered output to 0.
  - NextPC resets to RESET_PC.
- Latency: registered outputs update on the rising clk edge following an in_valid cycle.
- in_valid=0: out_valid=0, RegWr/MemRd/MemWr=0, and the other registered outputs hold their values.
- ALUctr encoding:
  - add=0000, sub=1000, sll=0001, slt=0010, sltu=1010, copyB=0011.
  - xor=0100, srl=0101, sra=1101, or=0110, and=0111.
- Shift amounts: shifts use B[4:0].
- Less output:
  - slt: signed A<B.
  - sltu: unsigned A<B.
  - ALUout = {31'b0, Less}.
- Zero output: (A-B)==0 under the sub encoding.
- Operand muxes:
  - A = ALUAsrc ? pc : rs1_data.
  - B selected by ALUBsrc: 00 rs2_data, 01 imm, 10 const 4, 11 const 0.
- Decode table (fields are ExtOP, ALUAsrc, ALUBsrc, ALUctr, Branch; any control not listed is 0):
  - lui 0110111: U,0,01,copyB,000; RegWr.
  - auipc 0010111: U,1,01,add,000; RegWr.
  - op-imm 0010011: I,0,01; ALUctr from func3; srai when func3=101 and func7[5]=1; RegWr.
  - op 0110011: x,0,00; ALUctr from func3 plus func7[5] (sub, sra); RegWr.
  - jal 1101111: J,1,10,add,001; RegWr.
  - jalr 1100111: I,1,10,add,010; RegWr.
  - branch 1100011: B,0,00,Branch=1{func3[2],func3[0]}. ALUctr per func3:
    - beq/bne: sub.
    - blt/bge: slt.
    - bltu/bgeu: sltu.
  - load 0000011: I,0,01,add; RegWr, MemToReg, MemRd.
  - store 0100011: S,0,01,add; MemWr.
  - Any other opcode: all controls 0, illegal=1.
- Branch encoding and PC sources (PCAsrc, PCBsrc):
  - 000 → 0,0.
  - 001 (jal) → 1,0.
  - 010 (jalr) → 1,1.
  - 100 (beq) → Zero,0.
  - 101 (bne) → !Zero,0.
  - 110 (blt/bltu) → Less,0.
  - 111 (bge/bgeu) → !Less,0.
- NextPC = (PCAsrc ? imm : 4) + (PCBsrc ? rs1_data : pc), modulo 2^32.
- For jalr, bit 0 of NextPC is forced to 0.
- Arithmetic wraps with no overflow flag.

Optional Feature:
- ILLEGAL_INST_EN
  - Defined: illegal is asserted for unsupported opcodes, and also for an op-type opcode whose func7 is not 0000000 or 0100000.
  - Undefined: illegal is tied to 0, and unsupported opcodes still decode to all-zero controls.

Decomposition:
- Package rv32_exec_pkg holds:
  - Opcode constants.
  - ALUctr, ExtOP, ALUBsrc and Branch encodings.
  - The RESET_PC default.
- Natural sub-module: rv32_alu, purely combinational, with ports A, B, ctr → out, Less, Zero.
- Control decode and branch condition stay in the top module as combinational logic.

Test Plan:
- Reset mid-run: drive rst=0 asynchronously → NextPC=32'h80000000, out_valid=0, RegWr=0, MemWr=0 immediately, without waiting for a clock edge.
- add and sub:
  - op=0110011, func3=000, func7=0000000, rs1=5, rs2=7 → next cycle ALUout=12, RegWr=1, NextPC=pc+4.
  - Same with func7=0100000 → ALUout=0xFFFFFFFE.
- Shifts and compares:
  - srai with rs1=0x80000000, imm=4 (func7=0100000) → 0xF8000000.
  - slti with rs1=-1, imm=1 → 1.
  - sltiu with the same operands → 0.
- Branches, with pc=0x80000010 and imm=-16:
  - beq, rs1=rs2=3 → NextPC=0x80000000.
  - bne with the same operands → NextPC=0x80000014.
  - bltu with rs1=1, rs2=0xFFFFFFFF → taken.
- Jumps:
  - jal, pc=0x80000000, imm=8 → ALUout=0x80000004, NextPC=0x80000008.
  - jalr, rs1=0x80000101, imm=0 → NextPC=0x80000100.
- Memory and illegal:
  - lw with rs1=0x100, imm=4 → ALUout=0x104, MemRd=1, MemToReg=1, MemOp=010.
  - sw → MemWr=1, RegWr=0.
  - op=0000000 → illegal=1 when ILLEGAL_INST_EN is defined, all controls 0.

Source files
------------

// File: rtl/rv32_exec_pkg.sv
// Shared definitions for the RV32I execute/control stage.
//   - Major opcode constants (inst[6:0])
//   - ALU control, immediate format, ALU B-operand source and branch encodings
//   - Default reset PC
//   - Helper mapping func3 (plus the alternate bit) to an ALU control
package rv32_exec_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h8000_0000;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;

  typedef enum logic [3:0] {
    ALU_ADD   = 4'b0000,
    ALU_SLL   = 4'b0001,
    ALU_SLT   = 4'b0010,
    ALU_COPYB = 4'b0011,
    ALU_XOR   = 4'b0100,
    ALU_SRL   = 4'b0101,
    ALU_OR    = 4'b0110,
    ALU_AND   = 4'b0111,
    ALU_SUB   = 4'b1000,
    ALU_SLTU  = 4'b1010,
    ALU_SRA   = 4'b1101
  } alu_ctr_e;

  typedef enum logic [2:0] {
    EXT_I = 3'b000,
    EXT_U = 3'b001,
    EXT_S = 3'b010,
    EXT_B = 3'b011,
    EXT_J = 3'b100
  } ext_op_e;

  typedef enum logic [1:0] {
    BSRC_RS2  = 2'b00,
    BSRC_IMM  = 2'b01,
    BSRC_FOUR = 2'b10,
    BSRC_ZERO = 2'b11
  } alu_b_src_e;

  typedef enum logic [2:0] {
    BR_NONE = 3'b000,
    BR_JAL  = 3'b001,
    BR_JALR = 3'b010,
    BR_EQ   = 3'b100,
    BR_NE   = 3'b101,
    BR_LT   = 3'b110,
    BR_GE   = 3'b111
  } branch_e;

  // alt selects sub (func3=000) or sra (func3=101); callers decide when alt applies.
  function automatic alu_ctr_e alu_ctr_from_func3(input logic [2:0] func3, input logic alt);
    case (func3)
      3'b000:  return alt ? ALU_SUB : ALU_ADD;
      3'b001:  return ALU_SLL;
      3'b010:  return ALU_SLT;
      3'b011:  return ALU_SLTU;
      3'b100:  return ALU_XOR;
      3'b101:  return alt ? ALU_SRA : ALU_SRL;
      3'b110:  return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

endpackage

// File: rtl/rv32_alu.sv
// 32-bit combinational ALU.
//   A, B  : operands
//   ctr   : operation (alu_ctr_e)
//   out   : result
//   Less  : A<B, signed unless ctr selects sltu
//   Zero  : A-B == 0
module rv32_alu
  import rv32_exec_pkg::*;
(
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  alu_ctr_e    ctr,
  output logic [31:0] out,
  output logic        Less,
  output logic        Zero
);

  logic [31:0] diff;

  assign diff = A - B;
  assign Zero = (diff == 32'd0);
  assign Less = (ctr == ALU_SLTU) ? (A < B) : ($signed(A) < $signed(B));

  always_comb begin
    out = 32'd0;
    case (ctr)
      ALU_ADD:   out = A + B;
      ALU_SUB:   out = diff;
      ALU_SLL:   out = A << B[4:0];
      ALU_SLT,
      ALU_SLTU:  out = {31'd0, Less};
      ALU_COPYB: out = B;
      ALU_XOR:   out = A ^ B;
      ALU_SRL:   out = A >> B[4:0];
      ALU_SRA:   out = $unsigned($signed(A) >>> B[4:0]);
      ALU_OR:    out = A | B;
      ALU_AND:   out = A & B;
      default:   out = 32'd0;
    endcase
  end

endmodule

// File: rtl/rv32_exec_ctrl.sv
// Execute/control stage of the single-cycle RV32I core: control decode,
// ALU with operand muxes, branch evaluation and next-PC computation.
// All outputs except ExtOP are registered (one cycle after in_valid).
//
// Ports:
//   clk, rst (async, active-low)
//   in_valid, op, func3, func7, pc, rs1_data, rs2_data, imm : decoded inputs
//   ExtOP     : immediate format back to the IDU (combinational)
//   out_valid, RegWr, MemToReg, MemRd, MemWr, MemOp, ALUout, NextPC, illegal
//
// Build option: define ILLEGAL_INST_EN to report unsupported opcodes and
// op-type instructions with a non-standard func7 on `illegal`; otherwise
// `illegal` stays 0.
module rv32_exec_ctrl
  import rv32_exec_pkg::*;
#(
  parameter int          XLEN     = 32,
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  input  logic [6:0]      op,
  input  logic [2:0]      func3,
  input  logic [6:0]      func7,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic [XLEN-1:0] imm,
  output logic [2:0]      ExtOP,
  output logic            out_valid,
  output logic            RegWr,
  output logic            MemToReg,
  output logic            MemRd,
  output logic            MemWr,
  output logic [2:0]      MemOp,
  output logic [XLEN-1:0] ALUout,
  output logic [XLEN-1:0] NextPC,
  output logic            illegal
);

  typedef struct packed {
    ext_op_e    ext_op;
    logic       alu_a_src;
    alu_b_src_e alu_b_src;
    alu_ctr_e   alu_ctr;
    branch_e    branch;
    logic       reg_wr;
    logic       mem_to_reg;
    logic       mem_rd;
    logic       mem_wr;
    logic       illegal;
  } ctrl_t;

  ctrl_t ctrl;

  // ---------------- control decode ----------------
  // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    ctrl = '0;
    case (op)
      OP_LUI: begin
        ctrl.ext_op = EXT_U; ctrl.alu_b_src = BSRC_IMM; ctrl.alu_ctr = ALU_COPYB;
        ctrl.reg_wr = 1'b1;
      end
      OP_AUIPC: begin
        ctrl.ext_op = EXT_U; ctrl.alu_a_src = 1'b1; ctrl.alu_b_src = BSRC_IMM;
        ctrl.alu_ctr = ALU_ADD; ctrl.reg_wr = 1'b1;
      end
      OP_IMM: begin
        // Only srai uses the alternate encoding; addi has no immediate subtract.
        ctrl.ext_op = EXT_I; ctrl.alu_b_src = BSRC_IMM;
        ctrl.alu_ctr = alu_ctr_from_func3(func3, (func3 == 3'b101) && func7[5]);
        ctrl.reg_wr = 1'b1;
      end
      OP_REG: begin
        ctrl.alu_b_src = BSRC_RS2;
        ctrl.alu_ctr = alu_ctr_from_func3(func3, func7[5]);
        ctrl.reg_wr = 1'b1;
`ifdef ILLEGAL_INST_EN
        ctrl.illegal = (func7 != 7'b0000000) && (func7 != 7'b0100000);
`endif
      end
      OP_JAL: begin
        // rd gets pc+4 through the ALU; the target is formed by the PC adder.
        ctrl.ext_op = EXT_J; ctrl.alu_a_src = 1'b1; ctrl.alu_b_src = BSRC_FOUR;
        ctrl.alu_ctr = ALU_ADD; ctrl.branch = BR_JAL; ctrl.reg_wr = 1'b1;
      end
      OP_JALR: begin
        ctrl.ext_op = EXT_I; ctrl.alu_a_src = 1'b1; ctrl.alu_b_src = BSRC_FOUR;
        ctrl.alu_ctr = ALU_ADD; ctrl.branch = BR_JALR; ctrl.reg_wr = 1'b1;
      end
      OP_BRANCH: begin
        ctrl.ext_op = EXT_B; ctrl.alu_b_src = BSRC_RS2;
        ctrl.branch = branch_e'({1'b1, func3[2], func3[0]});
        case (func3[2:1])
          2'b10:   ctrl.alu_ctr = ALU_SLT;
          2'b11:   ctrl.alu_ctr = ALU_SLTU;
          default: ctrl.alu_ctr = ALU_SUB;
        endcase
      end
      OP_LOAD: begin
        ctrl.ext_op = EXT_I; ctrl.alu_b_src = BSRC_IMM; ctrl.alu_ctr = ALU_ADD;
        ctrl.reg_wr = 1'b1; ctrl.mem_to_reg = 1'b1; ctrl.mem_rd = 1'b1;
      end
      OP_STORE: begin
        ctrl.ext_op = EXT_S; ctrl.alu_b_src = BSRC_IMM; ctrl.alu_ctr = ALU_ADD;
        ctrl.mem_wr = 1'b1;
      end
      default: begin
`ifdef ILLEGAL_INST_EN
        ctrl.illegal = 1'b1;
`endif
      end
    endcase
  end

`ifndef ILLEGAL_INST_EN
  // Only func7[5] matters when illegal-instruction checking is compiled out.
  logic unused_func7;
  assign unused_func7 = ^{func7[6], func7[4:0]};
`endif

  assign ExtOP = ctrl.ext_op;

  // ---------------- ALU and operand muxes ----------------
  logic [31:0] alu_a, alu_b, alu_out;
  logic        alu_less, alu_zero;

  assign alu_a = ctrl.alu_a_src ? pc : rs1_data;

  always_comb begin
    alu_b = 32'd0;
    case (ctrl.alu_b_src)
      BSRC_RS2:  alu_b = rs2_data;
      BSRC_IMM:  alu_b = imm;
      BSRC_FOUR: alu_b = 32'd4;
      default:   alu_b = 32'd0;
    endcase
  end

  rv32_alu u_alu (
    .A    (alu_a),
    .B    (alu_b),
    .ctr  (ctrl.alu_ctr),
    .out  (alu_out),
    .Less (alu_less),
    .Zero (alu_zero)
  );

  // ---------------- branch condition and next PC ----------------
  logic        pc_a_src, pc_b_src;
  logic [31:0] next_pc;

  always_comb begin
    pc_a_src = 1'b0;
    pc_b_src = 1'b0;
    case (ctrl.branch)
      BR_JAL:  pc_a_src = 1'b1;
      BR_JALR: begin pc_a_src = 1'b1; pc_b_src = 1'b1; end
      BR_EQ:   pc_a_src = alu_zero;
      BR_NE:   pc_a_src = ~alu_zero;
      BR_LT:   pc_a_src = alu_less;
      BR_GE:   pc_a_src = ~alu_less;
      default: pc_a_src = 1'b0;
    endcase
    next_pc = (pc_a_src ? imm : 32'd4) + (pc_b_src ? rs1_data : pc);
    if (ctrl.branch == BR_JALR) next_pc[0] = 1'b0;
  end

  // ---------------- output registers ----------------
  logic        out_valid_d, out_valid_q;
  logic        reg_wr_d, reg_wr_q;
  logic        mem_to_reg_d, mem_to_reg_q;
  logic        mem_rd_d, mem_rd_q;
  logic        mem_wr_d, mem_wr_q;
  logic [2:0]  mem_op_d, mem_op_q;
  logic [31:0] alu_out_d, alu_out_q;
  logic [31:0] next_pc_d, next_pc_q;
  logic        illegal_d, illegal_q;

  // Idle cycles drop the write/valid strobes but keep the last datapath values.
  always_comb begin
    out_valid_d  = in_valid;
    reg_wr_d     = 1'b0;
    mem_rd_d     = 1'b0;
    mem_wr_d     = 1'b0;
    mem_to_reg_d = mem_to_reg_q;
    mem_op_d     = mem_op_q;
    alu_out_d    = alu_out_q;
    next_pc_d    = next_pc_q;
    illegal_d    = illegal_q;
    if (in_valid) begin
      reg_wr_d     = ctrl.reg_wr;
      mem_rd_d     = ctrl.mem_rd;
      mem_wr_d     = ctrl.mem_wr;
      mem_to_reg_d = ctrl.mem_to_reg;
      mem_op_d     = (ctrl.mem_rd || ctrl.mem_wr) ? func3 : 3'b000;
      alu_out_d    = alu_out;
      next_pc_d    = next_pc;
      illegal_d    = ctrl.illegal;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid_q  <= 1'b0;
      reg_wr_q     <= 1'b0;
      mem_to_reg_q <= 1'b0;
      mem_rd_q     <= 1'b0;
      mem_wr_q     <= 1'b0;
      mem_op_q     <= 3'b000;
      alu_out_q    <= 32'd0;
      next_pc_q    <= RESET_PC;
      illegal_q    <= 1'b0;
    end else begin
      out_valid_q  <= out_valid_d;
      reg_wr_q     <= reg_wr_d;
      mem_to_reg_q <= mem_to_reg_d;
      mem_rd_q     <= mem_rd_d;
      mem_wr_q     <= mem_wr_d;
      mem_op_q     <= mem_op_d;
      alu_out_q    <= alu_out_d;
      next_pc_q    <= next_pc_d;
      illegal_q    <= illegal_d;
    end
  end

  assign out_valid = out_valid_q;
  assign RegWr     = reg_wr_q;
  assign MemToReg  = mem_to_reg_q;
  assign MemRd     = mem_rd_q;
  assign MemWr     = mem_wr_q;
  assign MemOp     = mem_op_q;
  assign ALUout    = alu_out_q;
  assign NextPC    = next_pc_q;
  assign illegal   = illegal_q;

endmodule

// File: tb/tb_rv32_exec_ctrl.sv
// Directed self-checking bench for rv32_exec_ctrl. Inputs are driven one
// time unit after the rising edge; registered outputs are sampled one time
// unit after the following rising edge.
module tb_rv32_exec_ctrl;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [6:0]  op;
  logic [2:0]  func3;
  logic [6:0]  func7;
  logic [31:0] pc, rs1_data, rs2_data, imm;
  logic [2:0]  ExtOP;
  logic        out_valid, RegWr, MemToReg, MemRd, MemWr, illegal;
  logic [2:0]  MemOp;
  logic [31:0] ALUout, NextPC;

  int n_checks = 0;
  int n_errors = 0;

  rv32_exec_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .op        (op),
    .func3     (func3),
    .func7     (func7),
    .pc        (pc),
    .rs1_data  (rs1_data),
    .rs2_data  (rs2_data),
    .imm       (imm),
    .ExtOP     (ExtOP),
    .out_valid (out_valid),
    .RegWr     (RegWr),
    .MemToReg  (MemToReg),
    .MemRd     (MemRd),
    .MemWr     (MemWr),
    .MemOp     (MemOp),
    .ALUout    (ALUout),
    .NextPC    (NextPC),
    .illegal   (illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [6:0] o, input logic [2:0] f3,
                       input logic [6:0] f7, input logic [31:0] p, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] im);
    in_valid = v; op = o; func3 = f3; func7 = f7;
    pc = p; rs1_data = a; rs2_data = b; imm = im;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  localparam logic [6:0] R  = 7'b0110011;
  localparam logic [6:0] I  = 7'b0010011;
  localparam logic [6:0] BR = 7'b1100011;
  localparam logic [6:0] F7_ALT = 7'b0100000;

  initial begin
    drive(1'b0, 7'd0, 3'd0, 7'd0, 32'd0, 32'd0, 32'd0, 32'd0);
    rst = 1'b1;
    #1 rst = 1'b0;
    #1;
    check("reset NextPC",    NextPC,    32'h8000_0000);
    check("reset out_valid", {31'd0, out_valid}, 32'd0);
    check("reset ALUout",    ALUout,    32'd0);
    check("reset RegWr",     {31'd0, RegWr}, 32'd0);
    @(negedge clk) rst = 1'b1;
    step();

    // add / sub
    drive(1'b1, R, 3'b000, 7'd0, 32'h0000_1000, 32'd5, 32'd7, 32'd0);
    step();
    check("add ALUout",    ALUout, 32'd12);
    check("add RegWr",     {31'd0, RegWr}, 32'd1);
    check("add NextPC",    NextPC, 32'h0000_1004);
    check("add out_valid", {31'd0, out_valid}, 32'd1);
    drive(1'b1, R, 3'b000, F7_ALT, 32'h0000_1000, 32'd5, 32'd7, 32'd0);
    step();
    check("sub ALUout", ALUout, 32'hFFFF_FFFE);

    // register shifts: only B[4:0] is the shift amount
    drive(1'b1, R, 3'b101, F7_ALT, 32'h0, 32'h8000_0000, 32'h0000_0024, 32'd0);
    step();
    check("sra ALUout", ALUout, 32'hF800_0000);
    drive(1'b1, R, 3'b101, 7'd0, 32'h0, 32'h8000_0000, 32'h0000_0024, 32'd0);
    step();
    check("srl ALUout", ALUout, 32'h0800_0000);
    drive(1'b1, R, 3'b001, 7'd0, 32'h0, 32'h0000_0003, 32'h0000_0021, 32'd0);
    step();
    check("sll ALUout", ALUout, 32'h0000_0006);
    drive(1'b1, R, 3'b100, 7'd0, 32'h0, 32'hF0F0_1234, 32'h0FF0_FFFF, 32'd0);
    step();
    check("xor ALUout", ALUout, 32'hFF00_EDCB);
    drive(1'b1, R, 3'b110, 7'd0, 32'h0, 32'hF0F0_1234, 32'h0FF0_FFFF, 32'd0);
    step();
    check("or ALUout", ALUout, 32'hFFF0_FFFF);
    drive(1'b1, R, 3'b111, 7'd0, 32'h0, 32'hF0F0_1234, 32'h0FF0_FFFF, 32'd0);
    step();
    check("and ALUout", ALUout, 32'h00F0_1234);

    // immediate shifts and compares
    drive(1'b1, I, 3'b101, F7_ALT, 32'h0, 32'h8000_0000, 32'd0, 32'd4);
    #1 check("op-imm ExtOP", {29'd0, ExtOP}, 32'd0);
    step();
    check("srai ALUout", ALUout, 32'hF800_0000);
    drive(1'b1, I, 3'b010, 7'd0, 32'h0, 32'hFFFF_FFFF, 32'd0, 32'd1);
    step();
    check("slti ALUout", ALUout, 32'd1);
    drive(1'b1, I, 3'b011, 7'd0, 32'h0, 32'hFFFF_FFFF, 32'd0, 32'd1);
    step();
    check("sltiu ALUout", ALUout, 32'd0);
    // addi never subtracts even if imm[10] (func7[5]) is set
    drive(1'b1, I, 3'b000, F7_ALT, 32'h0, 32'd10, 32'd0, 32'd3);
    step();
    check("addi alt ALUout", ALUout, 32'd13);

    // branches: pc=0x80000010, imm=-16
    drive(1'b1, BR, 3'b000, 7'd0, 32'h8000_0010, 32'd3, 32'd3, 32'hFFFF_FFF0);
    #1 check("branch ExtOP", {29'd0, ExtOP}, 32'd3);
    step();
    check("beq taken NextPC", NextPC, 32'h8000_0000);
    check("beq RegWr", {31'd0, RegWr}, 32'd0);
    drive(1'b1, BR, 3'b001, 7'd0, 32'h8000_0010, 32'd3, 32'd3, 32'hFFFF_FFF0);
    step();
    check("bne not-taken NextPC", NextPC, 32'h8000_0014);
    drive(1'b1, BR, 3'b110, 7'd0, 32'h8000_0010, 32'd1, 32'hFFFF_FFFF, 32'hFFFF_FFF0);
    step();
    check("bltu taken NextPC", NextPC, 32'h8000_0000);
    drive(1'b1, BR, 3'b100, 7'd0, 32'h8000_0010, 32'd1, 32'hFFFF_FFFF, 32'hFFFF_FFF0);
    step();
    check("blt not-taken NextPC", NextPC, 32'h8000_0014);
    drive(1'b1, BR, 3'b101, 7'd0, 32'h8000_0010, 32'd1, 32'hFFFF_FFFF, 32'hFFFF_FFF0);
    step();
    check("bge taken NextPC", NextPC, 32'h8000_0000);

    // jumps
    drive(1'b1, 7'b1101111, 3'b000, 7'd0, 32'h8000_0000, 32'd0, 32'd0, 32'd8);
    #1 check("jal ExtOP", {29'd0, ExtOP}, 32'd4);
    step();
    check("jal ALUout", ALUout, 32'h8000_0004);
    check("jal NextPC", NextPC, 32'h8000_0008);
    check("jal RegWr",  {31'd0, RegWr}, 32'd1);
    drive(1'b1, 7'b1100111, 3'b000, 7'd0, 32'h8000_0000, 32'h8000_0101, 32'd0, 32'd0);
    step();
    check("jalr NextPC", NextPC, 32'h8000_0100);
    check("jalr ALUout", ALUout, 32'h8000_0004);

    // upper immediates
    drive(1'b1, 7'b0110111, 3'b000, 7'd0, 32'h8000_0000, 32'h0000_FFFF, 32'd0, 32'h1234_5000);
    #1 check("lui ExtOP", {29'd0, ExtOP}, 32'd1);
    step();
    check("lui ALUout", ALUout, 32'h1234_5000);
    drive(1'b1, 7'b0010111, 3'b000, 7'd0, 32'h8000_0000, 32'h0000_FFFF, 32'd0, 32'h0000_1000);
    step();
    check("auipc ALUout", ALUout, 32'h8000_1000);

    // loads and stores
    drive(1'b1, 7'b0000011, 3'b010, 7'd0, 32'h0, 32'h0000_0100, 32'd0, 32'd4);
    step();
    check("lw ALUout",   ALUout, 32'h0000_0104);
    check("lw MemRd",    {31'd0, MemRd}, 32'd1);
    check("lw MemToReg", {31'd0, MemToReg}, 32'd1);
    check("lw MemOp",    {29'd0, MemOp}, 32'd2);
    check("lw RegWr",    {31'd0, RegWr}, 32'd1);
    drive(1'b1, 7'b0100011, 3'b010, 7'd0, 32'h0, 32'h0000_0200, 32'h0000_DEAD, 32'd8);
    #1 check("sw ExtOP", {29'd0, ExtOP}, 32'd2);
    step();
    check("sw MemWr",  {31'd0, MemWr}, 32'd1);
    check("sw RegWr",  {31'd0, RegWr}, 32'd0);
    check("sw MemRd",  {31'd0, MemRd}, 32'd0);
    check("sw ALUout", ALUout, 32'h0000_0208);

    // idle cycle: strobes drop, datapath outputs hold
    drive(1'b0, R, 3'b000, 7'd0, 32'h4000_0000, 32'd1, 32'd1, 32'd0);
    step();
    check("idle out_valid", {31'd0, out_valid}, 32'd0);
    check("idle MemWr",     {31'd0, MemWr}, 32'd0);
    check("idle ALUout",    ALUout, 32'h0000_0208);
    check("idle MemOp",     {29'd0, MemOp}, 32'd2);
    check("idle NextPC",    NextPC, 32'h0000_0004);

    // unsupported opcode: all controls zero
    drive(1'b1, 7'b0000000, 3'b010, 7'd0, 32'h0000_2000, 32'd1, 32'd2, 32'd0);
    step();
    check("bad-op RegWr", {31'd0, RegWr}, 32'd0);
    check("bad-op MemRd", {31'd0, MemRd}, 32'd0);
    check("bad-op MemWr", {31'd0, MemWr}, 32'd0);
    check("bad-op MemOp", {29'd0, MemOp}, 32'd0);
`ifdef ILLEGAL_INST_EN
    check("bad-op illegal", {31'd0, illegal}, 32'd1);
    drive(1'b1, R, 3'b000, 7'b0000001, 32'h0, 32'd1, 32'd2, 32'd0);
    step();
    check("bad-func7 illegal", {31'd0, illegal}, 32'd1);
    drive(1'b1, R, 3'b000, 7'd0, 32'h0, 32'd1, 32'd2, 32'd0);
    step();
    check("good-op illegal", {31'd0, illegal}, 32'd0);
`else
    check("bad-op illegal", {31'd0, illegal}, 32'd0);
`endif

    // asynchronous reset mid-run, away from any clock edge
    drive(1'b1, 7'b0100011, 3'b000, 7'd0, 32'h0000_3000, 32'h10, 32'd0, 32'd0);
    step();
    check("pre-reset MemWr", {31'd0, MemWr}, 32'd1);
    #2 rst = 1'b0;
    #1;
    check("async NextPC",    NextPC, 32'h8000_0000);
    check("async out_valid", {31'd0, out_valid}, 32'd0);
    check("async RegWr",     {31'd0, RegWr}, 32'd0);
    check("async MemWr",     {31'd0, MemWr}, 32'd0);
    check("async ALUout",    ALUout, 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
